matmult_param: RTL and testbench

Parametrised successor to the fixed 8x8 matrix multiplier. It stores an N x N operand A and an N x N operand B, loaded row by row. It computes C = A*B, or C = C + A*B in accumulate mode, one output row at a time, using N parallel multiply-accumulate lanes. Finished rows are streamed out over a valid/ready handshake, so the block can feed a downstream consumer that applies backpressure. Signed or unsigned arithmetic is selectable per run.

---
 rtl/matmult_param.sv | 165 ++++++++++++++++
 tb/tb_matmult_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmult_param.sv
// matmult_param: N x N matrix multiplier with N parallel MAC lanes.
// Operands A and B are loaded row by row while idle. A run computes
// C = A*B (or C += A*B) one output row at a time. Each finished row is
// streamed out over a valid/ready handshake and written back into C
// when it is accepted.
module matmult_param #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int CW = 2*DW+AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_a,
  input  logic [AW-1:0]   addra,
  input  logic [N*DW-1:0] inpa,
  input  logic            wr_b,
  input  logic [AW-1:0]   addrb,
  input  logic [N*DW-1:0] inpb,
  input  logic            start,
  input  logic            acc_mode,
  input  logic            signed_mode,
  output logic            busy,
  output logic [N*CW-1:0] c_row,
  output logic [AW-1:0]   c_row_idx,
  output logic            c_valid,
  input  logic            c_ready,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(N-1);

  state_t                 state;
  logic [N*DW-1:0]        a_mem [N];
  logic [N*DW-1:0]        b_mem [N];
  logic [N*CW-1:0]        c_mem [N];
  logic [AW-1:0]          row_i;
  logic [AW-1:0]          k_idx;
  logic                   acc_mode_q;
  logic                   signed_q;

  // acc_p1 holds the running row sums; the _p0 signals are the combinational
  // products/sums of the current k step feeding it.
  logic [DW-1:0]          a_el_p0;
  logic signed [CW-1:0]   acc_nxt_p0 [N];
  logic [N*CW-1:0]        acc_nxt_flat_p0;
  logic signed [CW-1:0]   acc_p1 [N];

  // Widen an operand element to the result width, honouring signedness.
  function automatic logic signed [CW-1:0] ext(input logic [DW-1:0] x,
                                               input logic          sgn);
    logic sx;
    sx = sgn & x[DW-1];
    return {{(CW-DW){sx}}, x};
  endfunction

  // One multiply-accumulate step; the sum deliberately wraps modulo 2^CW,
  // which is also what makes two's-complement results come out right.
  function automatic logic signed [CW-1:0] wrap_mac(input logic signed [CW-1:0] acc,
                                                    input logic signed [CW-1:0] a,
                                                    input logic signed [CW-1:0] b);
    logic signed [CW-1:0] prod;
    prod = a * b;
    return acc + prod;
  endfunction

  // Stage p0: A[i][k] is broadcast to all lanes, lane j takes B[k][j].
  always_comb begin
    a_el_p0         = a_mem[row_i][k_idx*DW +: DW];
    acc_nxt_flat_p0 = '0;
    for (int j = 0; j < N; j++) begin
      acc_nxt_p0[j] = wrap_mac(acc_p1[j], ext(a_el_p0, signed_q),
                               ext(b_mem[k_idx][j*DW +: DW], signed_q));
      acc_nxt_flat_p0[j*CW +: CW] = acc_nxt_p0[j];
    end
  end

  // Operand banks: writable only while idle so a run sees frozen operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) begin
        a_mem[r] <= '0;
        b_mem[r] <= '0;
      end
    end else if (state == IDLE) begin
      if (wr_a) a_mem[addra] <= inpa;
      if (wr_b) b_mem[addrb] <= inpb;
    end
  end

  // Stage p1: run controller, accumulators, result bank and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      row_i      <= '0;
      k_idx      <= '0;
      acc_mode_q <= 1'b0;
      signed_q   <= 1'b0;
      busy       <= 1'b0;
      c_valid    <= 1'b0;
      done       <= 1'b0;
      c_row      <= '0;
      c_row_idx  <= '0;
      for (int r = 0; r < N; r++) begin
        c_mem[r]  <= '0;
        acc_p1[r] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc_mode_q <= acc_mode;
            signed_q   <= signed_mode;
            row_i      <= '0;
            k_idx      <= '0;
            for (int j = 0; j < N; j++)
              acc_p1[j] <= acc_mode ? c_mem[0][j*CW +: CW] : '0;
            busy       <= 1'b1;
            state      <= MAC;
          end
        end
        MAC: begin
          for (int j = 0; j < N; j++)
            acc_p1[j] <= acc_nxt_p0[j];
          if (k_idx == LAST) begin
            k_idx     <= '0;
            c_row     <= acc_nxt_flat_p0;
            c_row_idx <= row_i;
            c_valid   <= 1'b1;
            state     <= OUT;
          end else begin
            k_idx <= k_idx + 1'b1;
          end
        end
        OUT: begin
          if (c_ready) begin
            c_mem[row_i] <= c_row;
            c_valid      <= 1'b0;
            if (row_i == LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row_i <= row_i + 1'b1;
              k_idx <= '0;
              for (int j = 0; j < N; j++)
                acc_p1[j] <= acc_mode_q ? c_mem[row_i + 1'b1][j*CW +: CW] : '0;
              state <= MAC;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmult_param.sv
// Directed testbench for matmult_param at N=4, DW=8.
module tb_matmult_param;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int CW = 2*DW+AW;

  logic            clk;
  logic            rst;
  logic            wr_a;
  logic [AW-1:0]   addra;
  logic [N*DW-1:0] inpa;
  logic            wr_b;
  logic [AW-1:0]   addrb;
  logic [N*DW-1:0] inpb;
  logic            start;
  logic            acc_mode;
  logic            signed_mode;
  logic            busy;
  logic [N*CW-1:0] c_row;
  logic [AW-1:0]   c_row_idx;
  logic            c_valid;
  logic            c_ready;
  logic            done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [N*DW-1:0] ta [N];
  logic [N*DW-1:0] tb_rows [N];
  logic [N*CW-1:0] got [N];
  int              got_idx [N];
  int              vcyc [N];
  int              nrows;
  int              lat;
  int              t0;

  matmult_param #(.N(N), .DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .wr_a(wr_a), .addra(addra), .inpa(inpa),
    .wr_b(wr_b), .addrb(addrb), .inpb(inpb),
    .start(start), .acc_mode(acc_mode), .signed_mode(signed_mode),
    .busy(busy), .c_row(c_row), .c_row_idx(c_row_idx),
    .c_valid(c_valid), .c_ready(c_ready), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*CW-1:0] fill_row(input logic [CW-1:0] v);
    logic [N*CW-1:0] r;
    for (int j = 0; j < N; j++) r[j*CW +: CW] = v;
    return r;
  endfunction

  function automatic logic [N*CW-1:0] seq_row(input int base);
    logic [N*CW-1:0] r;
    for (int j = 0; j < N; j++) r[j*CW +: CW] = CW'(base + j);
    return r;
  endfunction

  // Write ta/tb_rows into both banks, one row per cycle.
  task automatic load_ab();
    for (int r = 0; r < N; r++) begin
      wr_a = 1'b1; addra = AW'(r); inpa = ta[r];
      wr_b = 1'b1; addrb = AW'(r); inpb = tb_rows[r];
      step();
    end
    wr_a = 1'b0; wr_b = 1'b0;
  endtask

  task automatic set_identity_a();
    for (int r = 0; r < N; r++) begin
      ta[r] = '0;
      ta[r][r*DW +: DW] = 8'd1;
    end
  endtask

  task automatic set_b_const(input logic [DW-1:0] v);
    for (int r = 0; r < N; r++) tb_rows[r] = {N{v}};
  endtask

  // Start a run and collect the emitted rows. Optionally stall row bp_row
  // for bp_len cycles, and optionally poke start/wr_a during MAC.
  task automatic run(input logic am, input logic sm, input int bp_row,
                     input int bp_len, input bit inj, output int done_lat);
    int  r;
    int  cnt;
    bit  fin;
    acc_mode = am; signed_mode = sm; start = 1'b1; c_ready = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0; acc_mode = 1'b0; signed_mode = 1'b0;
    chk("busy_in_run", busy, 1'b1);
    r = 0; cnt = 0; fin = 0; done_lat = -1;
    for (int q = 0; q < N; q++) begin got[q] = 'x; got_idx[q] = -1; vcyc[q] = -1; end
    while (!fin && cnt < 300) begin
      if (inj && cnt == 1) begin
        start = 1'b1; wr_a = 1'b1; addra = '0; inpa = {N{8'h55}};
      end else if (inj && cnt == 2) begin
        start = 1'b0; wr_a = 1'b0;
      end
      if (c_valid) begin
        if (r < N) begin
          got[r] = c_row; got_idx[r] = int'(c_row_idx); vcyc[r] = cyc - t0;
        end
        if (r == bp_row) begin
          c_ready = 1'b0;
          for (int h = 0; h < bp_len; h++) begin
            step(); cnt++;
            chk("bp_valid", c_valid, 1'b1);
            chk("bp_row", c_row, got[r]);
            chk("bp_idx", c_row_idx, AW'(r));
          end
          c_ready = 1'b1;
        end
        r++;
      end
      if (done) begin
        done_lat = cyc - t0;
        fin = 1;
        chk("busy_at_done", busy, 1'b0);
      end else begin
        step(); cnt++;
      end
    end
    nrows = r;
    step();
  endtask

  task automatic check_rows_const(input string tag, input logic [CW-1:0] v);
    chk({tag, "_nrows"}, nrows, N);
    for (int r = 0; r < N; r++) begin
      chk($sformatf("%s_row%0d", tag, r), got[r], fill_row(v));
      chk($sformatf("%s_idx%0d", tag, r), got_idx[r], r);
    end
  endtask

  initial begin
    rst = 1'b0; wr_a = 0; addra = '0; inpa = '0; wr_b = 0; addrb = '0; inpb = '0;
    start = 0; acc_mode = 0; signed_mode = 0; c_ready = 1'b1;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", c_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_crow", c_row, '0);
    chk("rst_idx", c_row_idx, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Identity times B
    set_identity_a();
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) tb_rows[r][j*DW +: DW] = DW'(4*r + j + 1);
    load_ab();
    run(1'b0, 1'b0, -1, 0, 1'b0, lat);
    chk("id_nrows", nrows, N);
    for (int r = 0; r < N; r++) begin
      chk($sformatf("id_row%0d", r), got[r], seq_row(4*r + 1));
      chk($sformatf("id_idx%0d", r), got_idx[r], r);
      chk($sformatf("id_vcyc%0d", r), vcyc[r], 5 + 5*r);
    end
    chk("id_done_lat", lat, 21);

    // Signed / unsigned with all-ones A
    for (int r = 0; r < N; r++) ta[r] = {N{8'hFF}};
    set_b_const(8'h02);
    load_ab();
    run(1'b0, 1'b1, -1, 0, 1'b0, lat);
    check_rows_const("sgn", 18'h3FFF8);
    run(1'b0, 1'b0, -1, 0, 1'b0, lat);
    check_rows_const("uns", 18'h007F8);

    // Backpressure on row 1
    run(1'b0, 1'b0, 1, 7, 1'b0, lat);
    check_rows_const("bp", 18'h007F8);
    chk("bp_vcyc2", vcyc[2], 22);
    chk("bp_done_lat", lat, 28);

    // Accumulate
    set_identity_a();
    set_b_const(8'd3);
    load_ab();
    run(1'b0, 1'b0, -1, 0, 1'b0, lat);
    check_rows_const("acc0", 18'd3);
    run(1'b1, 1'b0, -1, 0, 1'b0, lat);
    check_rows_const("acc1", 18'd6);
    chk("acc1_done_lat", lat, 21);
    run(1'b0, 1'b0, -1, 0, 1'b0, lat);
    check_rows_const("acc2", 18'd3);

    // start / wr_a during MAC are ignored
    run(1'b0, 1'b0, -1, 0, 1'b1, lat);
    check_rows_const("ill", 18'd3);
    chk("ill_done_lat", lat, 21);
    run(1'b0, 1'b0, -1, 0, 1'b0, lat);
    check_rows_const("ill_after", 18'd3);

    // Reset during MAC of row 2
    acc_mode = 1'b0; signed_mode = 1'b0; start = 1'b1; c_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    chk("mid_busy_before", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_valid", c_valid, 1'b0);
    chk("mid_done", done, 1'b0);
    chk("mid_crow", c_row, '0);
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("mid_valid_after", c_valid, 1'b0);
    run(1'b1, 1'b0, -1, 0, 1'b0, lat);
    check_rows_const("zero", 18'd0);
    chk("zero_done_lat", lat, 21);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
